sdram_cmd_responder: RTL and testbench
======================================

// Module: sdram_cmd_responder
// PURPOSE
//  SDRAM-side responder for the command_generate pin interface: samples CKE/CSn/RASn/CASn/WEn/BA/A/DQM/DQ,
//  decodes commands, tracks open row per bank, stores write data in a reduced-size array, returns read data
//  after CAS latency. Sits opposite the controller in block-level benches; flags protocol violations (sticky).
// PARAMETERS
//  ROW_MW      3   low row-address bits backed by storage (rows aliased modulo 2^ROW_MW)
//  COL_MW      8   column-address bits backed by storage (iAddr[COL_MW-1:0])
//  CL_DEFAULT  2   CAS latency after reset (legal 2 or 3)
//  TRCD        2   min cycles ACT->RD/WR same bank
// PORTS
//  sclk      in   1   clock, all logic on rising edge
//  sresetn   in   1   synchronous active-low reset
//  iClkEn    in   1   CKE; 0 = command ignored, read pipeline frozen
//  iCsn      in   1   chip select, active low
//  iRasn     in   1   row strobe, active low
//  iCasn     in   1   column strobe, active low
//  iWen      in   1   write enable, active low
//  iBank     in   2   bank address
//  iAddr     in   11  row (ACT) / column + A10 (RD/WR/PRE) / mode (LMR)
//  iDqm      in   4   byte mask, 1 = byte masked
//  iDq       in   32  write data, sampled with WRITE command
//  oDq       out  32  read data
//  oDqOe     out  1   oDq valid/driven
//  oBankOpen out  4   bit b = bank b has open row
//  oErr      out  4   sticky: [0] ACT to open bank [1] RD/WR to closed bank [2] tRCD violation [3] REF/LMR w/ bank open
// BEHAVIOUR
//  Reset (sresetn=0 at edge): oDq=0, oDqOe=0, oBankOpen=0, oErr=0, CL=CL_DEFAULT, read pipe cleared,
//   tRCD counters=0. Storage not cleared. Reset mid-read discards in-flight data.
//  Decode when iClkEn=1 & iCsn=0 ({RASn,CASn,WEn}): 111 NOP; 011 ACT; 101 READ; 100 WRITE;
//   010 PRECHARGE; 001 AUTO-REFRESH; 000 LOAD-MODE; 110 ignored. iCsn=1 or iClkEn=0 -> no command.
//  ACT: row[b]<=iAddr, open[b]<=1, trcd[b]<=TRCD-1. Bank already open: oErr[0]<=1, row overwritten.
//  Each bank counter trcd[b] decrements to 0 every cycle with iClkEn=1.
//  READ/WRITE: address {iBank, row[b][ROW_MW-1:0], iAddr[COL_MW-1:0]}. Burst length 1.
//   Bank closed: oErr[1]<=1, access still performed with stale row. trcd[b]!=0: oErr[2]<=1, access performed.
//   iAddr[10]=1: auto-precharge, open[b]<=0 at same edge.
//  WRITE: byte lane i written with iDq[8i+7:8i] iff iDqm[i]=0; lands at the command edge.
//  READ: array read at command edge; bytes with iDqm[i]=1 (sampled at READ) returned as 8'h00.
//   oDq/oDqOe asserted exactly CL enabled cycles after READ edge, held 1 cycle; else oDqOe=0, oDq holds.
//   Back-to-back READs every cycle -> oDqOe continuous. 3-deep delay line, tap at CL.
//  WRITE to addr in same cycle as READ return: read data is pre-write (read occurred earlier).
//  PRECHARGE: iAddr[10]=1 closes all banks; else closes iBank. Closing idle bank legal, no error.
//  AUTO-REFRESH: no storage effect; any bank open -> oErr[3]<=1.
//  LOAD-MODE: CL<=iAddr[6:4] if 2 or 3, else CL unchanged; any bank open -> oErr[3]<=1;
//   reads in flight keep CL in effect at issue.
//  iClkEn=0: no decode, trcd and read pipe hold, oDqOe holds its value.
//  oErr bits clear only by reset. oBankOpen = open[3:0] registered.
// TESTING
//  1 reset, ACT b1 row 5, wait 2, WRITE b1 col 8 dq=32'hA5A5_1234 dqm=0, READ b1 col 8 -> oDqOe 2 cycles later,
//    oDq=32'hA5A5_1234, oErr=0.
//  2 WRITE dqm=4'b0101 dq=32'h1122_3344 over 32'hFFFF_FFFF, READ dqm=4'b1000 -> oDq=32'h00FF_33FF.
//  3 LOAD-MODE iAddr[6:4]=3, READ -> oDqOe exactly 3 cycles later; 4 back-to-back READs -> 4 consecutive valid beats.
//  4 READ with A10=1 -> oBankOpen[b]=0 next cycle; following READ same bank sets oErr[1]; ACT twice sets oErr[0].
//  5 ACT then READ next cycle (TRCD=2) -> oErr[2]=1, data still returned; REF with bank open -> oErr[3]=1.
//  6 READ issued, iClkEn=0 for 2 cycles -> return delayed 2 cycles; sresetn low mid-read -> no oDqOe, oErr=0.

Source files
------------

// File: rtl/sdram_cmd_responder.sv
// SDRAM-side pin responder: decodes commands, tracks open rows, stores
// write data, returns read data after CAS latency, flags sticky errors.
// Ports: sclk/sresetn; CKE/CSn/RASn/CASn/WEn/BA/A/DQM/DQ in;
//        oDq/oDqOe read return, oBankOpen per-bank state, oErr sticky.
module sdram_cmd_responder #(
  parameter int ROW_MW     = 3,
  parameter int COL_MW     = 8,
  parameter int CL_DEFAULT = 2,
  parameter int TRCD       = 2
) (
  input  logic        sclk,
  input  logic        sresetn,
  input  logic        iClkEn,
  input  logic        iCsn,
  input  logic        iRasn,
  input  logic        iCasn,
  input  logic        iWen,
  input  logic [1:0]  iBank,
  input  logic [10:0] iAddr,
  input  logic [3:0]  iDqm,
  input  logic [31:0] iDq,
  output logic [31:0] oDq,
  output logic        oDqOe,
  output logic [3:0]  oBankOpen,
  output logic [3:0]  oErr
);

  localparam int AW    = 2 + ROW_MW + COL_MW;
  localparam int DEPTH = 1 << AW;
  localparam int TW    = (TRCD > 1) ? $clog2(TRCD) : 1;

  logic [31:0] mem_q [DEPTH];

  logic [3:0]           open_q, open_d;
  logic [3:0]           err_q, err_d;
  logic [1:0]           cl_q, cl_d;
  logic [3:0][10:0]     row_q, row_d;
  logic [3:0][TW-1:0]   trcd_q, trcd_d;
  logic [2:0]           pv_q, pv_d;
  logic [2:0][31:0]     pd_q, pd_d;
  logic                 oe_q, oe_d;
  logic [31:0]          dq_q, dq_d;

  logic       cmd_v;
  logic [2:0] rcw;
  logic       is_act, is_rd, is_wr;
  logic       is_pre, is_ref, is_lmr;
  logic       any_open;

  logic [AW-1:0] mem_a;
  logic [31:0]   rd_word;

  assign cmd_v    = iClkEn & ~iCsn;
  assign rcw      = {iRasn, iCasn, iWen};
  assign any_open = |open_q;

  always_comb begin
    is_act = 1'b0;
    is_rd  = 1'b0;
    is_wr  = 1'b0;
    is_pre = 1'b0;
    is_ref = 1'b0;
    is_lmr = 1'b0;
    if (cmd_v) begin
      unique case (rcw)
        3'b011:  is_act = 1'b1;
        3'b101:  is_rd  = 1'b1;
        3'b100:  is_wr  = 1'b1;
        3'b010:  is_pre = 1'b1;
        3'b001:  is_ref = 1'b1;
        3'b000:  is_lmr = 1'b1;
        default: ;
      endcase
    end
  end

  // Closed banks still use the stale row register.
  assign mem_a = {iBank,
                  row_q[iBank][ROW_MW-1:0],
                  iAddr[COL_MW-1:0]};

  always_comb begin
    rd_word = mem_q[mem_a];
    for (int i = 0; i < 4; i++) begin
      if (iDqm[i]) rd_word[8*i +: 8] = 8'h00;
    end
  end

  always_ff @(posedge sclk) begin
    if (sresetn && is_wr) begin
      for (int i = 0; i < 4; i++) begin
        if (!iDqm[i])
          mem_q[mem_a][8*i +: 8] <= iDq[8*i +: 8];
      end
    end
  end

  always_comb begin
    open_d = open_q;
    err_d  = err_q;
    cl_d   = cl_q;
    row_d  = row_q;
    trcd_d = trcd_q;
    pv_d   = pv_q;
    pd_d   = pd_q;
    oe_d   = oe_q;
    dq_d   = dq_q;

    // Pipe, output and tRCD counters only move on enabled cycles.
    if (iClkEn) begin
      oe_d = pv_q[0];
      if (pv_q[0]) dq_d = pd_q[0];
      pv_d = {1'b0, pv_q[2:1]};
      pd_d = {32'h0, pd_q[2:1]};
      for (int b = 0; b < 4; b++) begin
        if (trcd_q[b] != '0)
          trcd_d[b] = trcd_q[b] - 1'b1;
      end
    end

    if (is_act) begin
      if (open_q[iBank]) err_d[0] = 1'b1;
      row_d[iBank]  = iAddr;
      open_d[iBank] = 1'b1;
      trcd_d[iBank] = TW'(TRCD - 1);
    end

    if (is_rd || is_wr) begin
      if (!open_q[iBank])        err_d[1] = 1'b1;
      if (trcd_q[iBank] != '0)   err_d[2] = 1'b1;
      if (iAddr[10])             open_d[iBank] = 1'b0;
    end

    // Entry enters at tap CL-1 so later CL changes cannot retime it.
    if (is_rd) begin
      pv_d[cl_q - 2'd1] = 1'b1;
      pd_d[cl_q - 2'd1] = rd_word;
    end

    if (is_pre) begin
      if (iAddr[10]) open_d = '0;
      else           open_d[iBank] = 1'b0;
    end

    if (is_ref && any_open) err_d[3] = 1'b1;

    if (is_lmr) begin
      if (any_open) err_d[3] = 1'b1;
      if (iAddr[6:4] == 3'd2 || iAddr[6:4] == 3'd3)
        cl_d = iAddr[5:4];
    end
  end

  always_ff @(posedge sclk) begin
    if (!sresetn) begin
      open_q <= '0;
      err_q  <= '0;
      cl_q   <= 2'(CL_DEFAULT);
      trcd_q <= '0;
      pv_q   <= '0;
      pd_q   <= '0;
      oe_q   <= 1'b0;
      dq_q   <= '0;
    end else begin
      open_q <= open_d;
      err_q  <= err_d;
      cl_q   <= cl_d;
      row_q  <= row_d;
      trcd_q <= trcd_d;
      pv_q   <= pv_d;
      pd_q   <= pd_d;
      oe_q   <= oe_d;
      dq_q   <= dq_d;
    end
  end

  assign oDq       = dq_q;
  assign oDqOe     = oe_q;
  assign oBankOpen = open_q;
  assign oErr      = err_q;

endmodule

// File: tb/tb_sdram_cmd_responder.sv
// Bench for sdram_cmd_responder: directed scenarios plus random
// traffic, all compared against a transaction-level model.
module tb_sdram_cmd_responder;

  localparam int CLD  = 2;
  localparam int TRCD = 2;

  localparam logic [2:0] C_NOP = 3'b111;
  localparam logic [2:0] C_ACT = 3'b011;
  localparam logic [2:0] C_RD  = 3'b101;
  localparam logic [2:0] C_WR  = 3'b100;
  localparam logic [2:0] C_PRE = 3'b010;
  localparam logic [2:0] C_REF = 3'b001;
  localparam logic [2:0] C_LMR = 3'b000;

  logic        sclk = 1'b0;
  logic        sresetn, ce, csn, rasn, casn, wen;
  logic [1:0]  bank;
  logic [10:0] addr;
  logic [3:0]  dqm;
  logic [31:0] dq;
  logic [31:0] oDq;
  logic        oDqOe;
  logic [3:0]  oBankOpen, oErr;

  always #5 sclk = ~sclk;

  sdram_cmd_responder dut (
    .sclk(sclk), .sresetn(sresetn), .iClkEn(ce),
    .iCsn(csn), .iRasn(rasn), .iCasn(casn), .iWen(wen),
    .iBank(bank), .iAddr(addr), .iDqm(dqm), .iDq(dq),
    .oDq(oDq), .oDqOe(oDqOe),
    .oBankOpen(oBankOpen), .oErr(oErr)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  typedef struct {
    int          due;
    logic [31:0] d;
    bit          k;
  } rd_t;

  bit   [3:0]  m_open, m_err;
  int          m_row [4];
  bit          m_rowk [4];
  int          m_act [4];
  int          m_cl;
  int          ecnt = 0;
  rd_t         q [$];
  logic        m_oe;
  logic [31:0] m_dq;
  bit          m_dqk;
  logic [31:0] mm [int];

  initial for (int b = 0; b < 4; b++) m_rowk[b] = 0;

  task automatic model_edge();
    int          a;
    rd_t         r;
    logic [31:0] w;
    if (!sresetn) begin
      m_open = '0; m_err = '0; m_cl = CLD;
      q.delete(); m_oe = 0; m_dq = '0; m_dqk = 1;
      for (int b = 0; b < 4; b++) m_act[b] = -100;
    end else if (ce) begin
      m_oe = 0;
      if (q.size() > 0 && q[0].due == ecnt) begin
        m_oe = 1; m_dq = q[0].d; m_dqk = q[0].k;
        void'(q.pop_front());
      end
      if (!csn) begin
        a = bank * 2048 + (m_row[bank] % 8) * 256
            + int'(addr[7:0]);
        case ({rasn, casn, wen})
          C_ACT: begin
            if (m_open[bank]) m_err[0] = 1;
            m_row[bank]  = int'(addr);
            m_rowk[bank] = 1;
            m_open[bank] = 1;
            m_act[bank]  = ecnt;
          end
          C_RD, C_WR: begin
            if (!m_open[bank]) m_err[1] = 1;
            if (ecnt - m_act[bank] < TRCD) m_err[2] = 1;
            if (wen == 1'b0) begin
              if (m_rowk[bank] && (mm.exists(a) || dqm == 0)) begin
                w = mm.exists(a) ? mm[a] : 32'h0;
                for (int i = 0; i < 4; i++)
                  if (!dqm[i]) w[8*i +: 8] = dq[8*i +: 8];
                mm[a] = w;
              end
            end else begin
              r.due = ecnt + m_cl;
              r.k   = m_rowk[bank] && mm.exists(a);
              r.d   = r.k ? mm[a] : 32'h0;
              for (int i = 0; i < 4; i++)
                if (dqm[i]) r.d[8*i +: 8] = 8'h00;
              q.push_back(r);
            end
            if (addr[10]) m_open[bank] = 0;
          end
          C_PRE: begin
            if (addr[10]) m_open = '0;
            else          m_open[bank] = 0;
          end
          C_REF: if (m_open != 0) m_err[3] = 1;
          C_LMR: begin
            if (m_open != 0) m_err[3] = 1;
            if (addr[6:4] == 3'd2 || addr[6:4] == 3'd3)
              m_cl = int'(addr[6:4]);
          end
          default: ;
        endcase
      end
      ecnt++;
    end
  endtask

  task automatic tick();
    @(posedge sclk);
    model_edge();
    #1;
    chk("oe", oDqOe, m_oe);
    if (m_dqk) chk("dq", oDq, m_dq);
    chk("open", oBankOpen, m_open);
    chk("err", oErr, m_err);
  endtask

  task automatic issue(input logic [2:0] c, input logic [1:0] b,
                       input logic [10:0] a, input logic [3:0] m,
                       input logic [31:0] d);
    sresetn = 1; ce = 1; csn = 0;
    {rasn, casn, wen} = c;
    bank = b; addr = a; dqm = m; dq = d;
    tick();
  endtask

  task automatic nop(input int n);
    for (int i = 0; i < n; i++) issue(C_NOP, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    sresetn = 0; ce = 1; csn = 1;
    {rasn, casn, wen} = C_NOP;
    tick(); tick();
  endtask

  logic [10:0] rows [5];
  int          k;

  initial begin
    rows[0] = 11'd0; rows[1] = 11'd1; rows[2] = 11'd8;
    rows[3] = 11'd9; rows[4] = 11'h409;
    sresetn = 0; ce = 1; csn = 1;
    {rasn, casn, wen} = C_NOP;
    bank = 0; addr = 0; dqm = 0; dq = 0;

    // 1: basic write/read
    do_reset();
    chk("rst_oe", oDqOe, 0);
    chk("rst_dq", oDq, 0);
    chk("rst_open", oBankOpen, 0);
    chk("rst_err", oErr, 0);
    issue(C_ACT, 1, 11'd5, 0, 0);
    nop(1);
    issue(C_WR, 1, 11'd8, 4'b0000, 32'hA5A5_1234);
    issue(C_RD, 1, 11'd8, 4'b0000, 0);
    nop(1);
    chk("t1_early", oDqOe, 0);
    nop(1);
    chk("t1_oe", oDqOe, 1);
    chk("t1_dq", oDq, 32'hA5A5_1234);
    chk("t1_err", oErr, 0);

    // 2: byte masks
    issue(C_WR, 1, 11'd9, 4'b0000, 32'hFFFF_FFFF);
    issue(C_WR, 1, 11'd9, 4'b0101, 32'h1122_3344);
    issue(C_RD, 1, 11'd9, 4'b1000, 0);
    nop(2);
    chk("t2_dq", oDq, 32'h00FF_33FF);

    // 3: CL=3 and back-to-back reads
    issue(C_PRE, 0, 11'h400, 0, 0);
    issue(C_LMR, 0, 11'h030, 0, 0);
    issue(C_ACT, 1, 11'd5, 0, 0);
    nop(1);
    issue(C_RD, 1, 11'd8, 0, 0);
    nop(2);
    chk("t3_early", oDqOe, 0);
    nop(1);
    chk("t3_oe", oDqOe, 1);
    chk("t3_dq", oDq, 32'hA5A5_1234);
    for (int i = 0; i < 7; i++) begin
      if (i < 4) issue(C_RD, 1, 11'(8 + i % 2), 0, 0);
      else       nop(1);
      chk("t3_burst", oDqOe, (i >= 3) ? 1 : 0);
    end
    issue(C_PRE, 0, 11'h400, 0, 0);
    issue(C_LMR, 0, 11'h020, 0, 0);
    chk("t3_err", oErr, 0);

    // 4: auto-precharge, closed-bank access, double ACT
    issue(C_ACT, 2, 11'd1, 0, 0);
    nop(1);
    issue(C_RD, 2, 11'h400, 0, 0);
    chk("t4_ap", oBankOpen[2], 0);
    issue(C_RD, 2, 11'h000, 0, 0);
    chk("t4_closed", oErr[1], 1);
    issue(C_ACT, 3, 11'd0, 0, 0);
    issue(C_ACT, 3, 11'd0, 0, 0);
    chk("t4_dblact", oErr[0], 1);

    // 5: tRCD violation, refresh with bank open
    do_reset();
    issue(C_ACT, 0, 11'd0, 0, 0);
    nop(1);
    issue(C_WR, 0, 11'd1, 0, 32'hCAFE_0001);
    issue(C_PRE, 0, 11'd0, 0, 0);
    chk("t5_noerr", oErr, 0);
    issue(C_ACT, 0, 11'd0, 0, 0);
    issue(C_RD, 0, 11'd1, 0, 0);
    chk("t5_trcd", oErr[2], 1);
    nop(1);
    issue(C_REF, 0, 0, 0, 0);
    chk("t5_oe", oDqOe, 1);
    chk("t5_dq", oDq, 32'hCAFE_0001);
    chk("t5_ref", oErr[3], 1);

    // 6: CKE stall, reset mid-read
    do_reset();
    issue(C_ACT, 1, 11'd5, 0, 0);
    nop(1);
    issue(C_RD, 1, 11'd8, 0, 0);
    ce = 0; csn = 1;
    tick(); tick();
    chk("t6_stall", oDqOe, 0);
    nop(1);
    chk("t6_early", oDqOe, 0);
    nop(1);
    chk("t6_oe", oDqOe, 1);
    chk("t6_dq", oDq, 32'hA5A5_1234);
    issue(C_RD, 1, 11'd8, 0, 0);
    sresetn = 0;
    tick();
    for (int i = 0; i < 3; i++) begin
      nop(1);
      chk("t6_rst_oe", oDqOe, 0);
    end
    chk("t6_rst_err", oErr, 0);

    // Random traffic over a pre-initialised region
    do_reset();
    for (int b = 0; b < 4; b++)
      for (int r = 0; r < 2; r++) begin
        issue(C_ACT, 2'(b), 11'(r), 0, 0);
        nop(1);
        for (int c = 0; c < 4; c++)
          issue(C_WR, 2'(b), 11'(c), 0, $urandom);
        issue(C_PRE, 2'(b), 0, 0, 0);
      end
    for (int n = 0; n < 4000; n++) begin
      sresetn = ($urandom_range(0, 99) >= 2);
      ce   = ($urandom_range(0, 7) != 0);
      csn  = ($urandom_range(0, 9) == 0);
      bank = 2'($urandom);
      dqm  = 4'($urandom);
      dq   = $urandom;
      k    = $urandom_range(0, 15);
      if (k < 3) begin
        {rasn, casn, wen} = C_ACT;
        addr = rows[$urandom_range(0, 4)];
      end else if (k < 10) begin
        {rasn, casn, wen} = (k < 7) ? C_RD : C_WR;
        addr = {($urandom_range(0, 3) == 0), 2'($urandom),
                6'b0, 2'($urandom)};
      end else if (k < 12) begin
        {rasn, casn, wen} = C_PRE;
        addr = {1'($urandom), 10'($urandom)};
      end else if (k == 12) begin
        {rasn, casn, wen} = C_REF;
        addr = 11'($urandom);
      end else if (k == 13) begin
        {rasn, casn, wen} = C_LMR;
        addr = {4'b0, 3'($urandom), 4'b0};
      end else if (k == 14) begin
        {rasn, casn, wen} = C_NOP;
        addr = 0;
      end else begin
        {rasn, casn, wen} = 3'b110;
        addr = 11'($urandom);
      end
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
